// File: rtl/ram_true_dual_port_pkg.sv
// Shared types and defaults for the dual-port RAM primitive.
// Imported by the RAM core and its single-port wrapper.
package ram_true_dual_port_pkg;

    typedef logic [63:0] u64;
    typedef u64          word_t;
    typedef logic [7:0]  strobe_t;

    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_DATA_WIDTH   = $bits(word_t);
    localparam int DEF_BYTE_WIDTH   = 8;
    localparam int DEF_READ_LATENCY = 0;

endpackage

// File: rtl/ram_single_port.sv
// Single-port RAM: the dual-port core with port 2 tied idle.
// Honours RAM_INIT_ZERO_EN through the core.
module ram_single_port
    import ram_true_dual_port_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BYTE_WIDTH   = DEF_BYTE_WIDTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    localparam int NUM_LANES   = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [NUM_LANES-1:0]  strobe,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] unused_rdata_2;

    ram_true_dual_port #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .BYTE_WIDTH   (BYTE_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .en_1     (en),
        .addr_1   (addr),
        .strobe_1 (strobe),
        .wdata_1  (wdata),
        .rdata_1  (rdata),
        .en_2     (1'b0),
        .addr_2   ('0),
        .strobe_2 ('0),
        .wdata_2  ('0),
        .rdata_2  (unused_rdata_2)
    );

endmodule

// File: rtl/ram_true_dual_port.sv
// Byte-lane-strobed true dual-port RAM, 0 or 1 cycle read latency.
// Optional macro RAM_INIT_ZERO_EN: memory powers up all-zero.
module ram_true_dual_port
    import ram_true_dual_port_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BYTE_WIDTH   = DEF_BYTE_WIDTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    localparam int NUM_LANES   = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [NUM_LANES-1:0]  strobe_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic [DATA_WIDTH-1:0] rdata_1,
    input  logic                  en_2,
    input  logic [ADDR_WIDTH-1:0] addr_2,
    input  logic [NUM_LANES-1:0]  strobe_2,
    input  logic [DATA_WIDTH-1:0] wdata_2,
    output logic [DATA_WIDTH-1:0] rdata_2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [NUM_LANES-1:0][BYTE_WIDTH-1:0] lane_word_t;

    lane_word_t mem [DEPTH];
    lane_word_t wlanes_1;
    lane_word_t wlanes_2;

    assign wlanes_1 = wdata_1;
    assign wlanes_2 = wdata_2;

`ifdef RAM_INIT_ZERO_EN
    // Power-up contents are all zero so early reads are defined.
    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            mem[a] = '0;
        end
    end
`endif

    // Lane-wise writes; port 2 is issued last so it wins shared lanes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (en_1 && strobe_1[i]) begin
                    mem[addr_1][i] <= wlanes_1[i];
                end
                if (en_2 && strobe_2[i]) begin
                    mem[addr_2][i] <= wlanes_2[i];
                end
            end
        end
    end

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lanes
        $error("BYTE_WIDTH must divide DATA_WIDTH");
    end

    if (READ_LATENCY == 0) begin : g_lat0
        assign rdata_1 = mem[addr_1];
        assign rdata_2 = mem[addr_2];
    end else if (READ_LATENCY == 1) begin : g_lat1
        // Read-first registered outputs, held while the port is idle.
        always_ff @(posedge clk) begin
            if (!reset) begin
                rdata_1 <= '0;
                rdata_2 <= '0;
            end else begin
                if (en_1) begin
                    rdata_1 <= mem[addr_1];
                end
                if (en_2) begin
                    rdata_2 <= mem[addr_2];
                end
            end
        end
    end else begin : g_bad_latency
        $error("READ_LATENCY must be 0 or 1");
    end

endmodule

// File: tb/tb_ram_true_dual_port.sv
// Bench for ram_true_dual_port: latency-1 64/8 dual port plus a
// latency-0 36/36 single-port wrapper, checked against a word model.
module tb_ram_true_dual_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_1, en_2;
    logic [7:0]  addr_1, addr_2;
    logic [7:0]  strobe_1, strobe_2;
    logic [63:0] wdata_1, wdata_2;
    logic [63:0] rdata_1, rdata_2;

    logic        en_s;
    logic [7:0]  addr_s;
    logic [0:0]  strobe_s;
    logic [35:0] wdata_s;
    logic [35:0] rdata_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_true_dual_port #(
        .ADDR_WIDTH   (8),
        .DATA_WIDTH   (64),
        .BYTE_WIDTH   (8),
        .READ_LATENCY (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en_1     (en_1),
        .addr_1   (addr_1),
        .strobe_1 (strobe_1),
        .wdata_1  (wdata_1),
        .rdata_1  (rdata_1),
        .en_2     (en_2),
        .addr_2   (addr_2),
        .strobe_2 (strobe_2),
        .wdata_2  (wdata_2),
        .rdata_2  (rdata_2)
    );

    ram_single_port #(
        .ADDR_WIDTH   (8),
        .DATA_WIDTH   (36),
        .BYTE_WIDTH   (36),
        .READ_LATENCY (0)
    ) dut_sp (
        .clk    (clk),
        .reset  (reset),
        .en     (en_s),
        .addr   (addr_s),
        .strobe (strobe_s),
        .wdata  (wdata_s),
        .rdata  (rdata_s)
    );

    // Model: memory words plus a per-lane "has been written" mask.
    logic [63:0] mm [256];
    logic [7:0]  kn [256];
    logic [35:0] ms [256];
    bit          ks [256];
    logic [63:0] er1, er2;
    bit          ev1 = 0, ev2 = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            er1 = '0;
            er2 = '0;
            ev1 = 1;
            ev2 = 1;
        end else begin
            if (en_1) begin
                er1 = mm[addr_1];
                ev1 = (kn[addr_1] == 8'hFF);
            end
            if (en_2) begin
                er2 = mm[addr_2];
                ev2 = (kn[addr_2] == 8'hFF);
            end
            for (int i = 0; i < 8; i++) begin
                if (en_1 && strobe_1[i]) begin
                    mm[addr_1][i*8 +: 8] = wdata_1[i*8 +: 8];
                    kn[addr_1][i] = 1'b1;
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (en_2 && strobe_2[i]) begin
                    mm[addr_2][i*8 +: 8] = wdata_2[i*8 +: 8];
                    kn[addr_2][i] = 1'b1;
                end
            end
            if (en_s && strobe_s[0]) begin
                ms[addr_s] = wdata_s;
                ks[addr_s] = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (ev1) chk("p1_model", rdata_1, er1);
        if (ev2) chk("p2_model", rdata_2, er2);
        if (ks[addr_s]) chk("sp_model", {28'h0, rdata_s}, {28'h0, ms[addr_s]});
    end

    task automatic step(input logic e1, input logic [7:0] a1,
                        input logic [7:0] s1, input logic [63:0] w1,
                        input logic e2, input logic [7:0] a2,
                        input logic [7:0] s2, input logic [63:0] w2);
        en_1 = e1; addr_1 = a1; strobe_1 = s1; wdata_1 = w1;
        en_2 = e2; addr_2 = a2; strobe_2 = s2; wdata_2 = w2;
        @(posedge clk);
        #3;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            kn[a] = '0;
            ks[a] = 0;
        end
        reset = 1'b0;
        en_s = 0; addr_s = 0; strobe_s = 0; wdata_s = 0;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_r1", rdata_1, 64'h0);
        chk("reset_r2", rdata_2, 64'h0);
        reset = 1'b1;

        step(1, 5, 8'hFF, 64'h1122334455667788, 0, 0, 0, 0);
        step(1, 5, 8'h00, 64'h0, 0, 0, 0, 0);
        chk("read_a5", rdata_1, 64'h1122334455667788);
        chk("model_a5", er1, 64'h1122334455667788);
        step(0, 6, 8'h00, 64'h0, 0, 0, 0, 0);
        chk("hold_a5", rdata_1, 64'h1122334455667788);

        step(1, 3, 8'hFF, 64'h0, 0, 0, 0, 0);
        step(1, 3, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 0, 0, 0, 0);
        step(1, 3, 8'h00, 64'h0, 0, 0, 0, 0);
        chk("partial", rdata_1, 64'h00000000AAAAAAAA);
        chk("model_partial", er1, 64'h00000000AAAAAAAA);

        step(1, 7, 8'hFF, 64'h1, 0, 0, 0, 0);
        step(1, 7, 8'hFF, 64'h2, 0, 0, 0, 0);
        chk("read_first_old", rdata_1, 64'h1);
        step(1, 7, 8'h00, 64'h0, 0, 0, 0, 0);
        chk("read_first_new", rdata_1, 64'h2);

        step(1, 9, 8'hFF, 64'h1111111111111111,
             1, 9, 8'hFF, 64'h2222222222222222);
        step(1, 9, 8'h00, 64'h0, 1, 9, 8'h00, 64'h0);
        chk("collide_full_p1", rdata_1, 64'h2222222222222222);
        chk("collide_full_p2", rdata_2, 64'h2222222222222222);
        step(1, 9, 8'hF0, 64'h1111111111111111,
             1, 9, 8'h0F, 64'h2222222222222222);
        step(1, 9, 8'h00, 64'h0, 0, 0, 0, 0);
        chk("collide_split", rdata_1, 64'h1111111122222222);
        chk("model_split", er1, 64'h1111111122222222);

        step(1, 9, 8'hFF, 64'h3333333333333333, 1, 9, 8'h00, 64'h0);
        chk("cross_old", rdata_2, 64'h1111111122222222);
        step(0, 0, 8'h00, 64'h0, 1, 9, 8'h00, 64'h0);
        chk("cross_new", rdata_2, 64'h3333333333333333);

        en_s = 1; addr_s = 2; strobe_s = 1; wdata_s = 36'h123456789;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sp_next", {28'h0, rdata_s}, 64'h123456789);
        addr_s = 4; wdata_s = 36'hABCDE0123;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        en_s = 0; strobe_s = 0;
        chk("sp_a4", {28'h0, rdata_s}, 64'hABCDE0123);
        addr_s = 2;
        #1;
        chk("sp_comb_a2", {28'h0, rdata_s}, 64'h123456789);

        step(1, 1, 8'hFF, 64'h5, 0, 0, 0, 0);
        reset = 1'b0;
        en_s = 1; strobe_s = 1; wdata_s = 36'hFFFFFFFFF;
        step(1, 1, 8'hFF, 64'h6, 0, 0, 0, 0);
        chk("mid_reset_r1", rdata_1, 64'h0);
        chk("mid_reset_r2", rdata_2, 64'h0);
        reset = 1'b1;
        en_s = 0; strobe_s = 0;
        step(1, 1, 8'h00, 64'h0, 1, 1, 8'h00, 64'h0);
        chk("after_reset_a1", rdata_1, 64'h5);
        chk("after_reset_a1_p2", rdata_2, 64'h5);
        chk("sp_reset_blocked", {28'h0, rdata_s}, 64'h123456789);

        step(0, 0, 0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
